// File: rtl/uart_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_ctrl_pkg
// Description : Shared definitions for the MMU-facing UART.
//               - MEM_* operation codes issued by the MEM stage / MMU
//               - UART register addresses (data / status), used by the MMU
//               - Serial FSM state encoding shared by the TX and RX paths
//               - Helpers that classify an op code as a load or a store
// Revision    : 1.0 - initial release
// ============================================================================
package uart_ctrl_pkg;

    // Memory operation codes presented by the MEM stage
    localparam logic [3:0] MEM_NOP = 4'd0;
    localparam logic [3:0] MEM_LB  = 4'd1;
    localparam logic [3:0] MEM_LBU = 4'd2;
    localparam logic [3:0] MEM_LH  = 4'd3;
    localparam logic [3:0] MEM_LHU = 4'd4;
    localparam logic [3:0] MEM_LW  = 4'd5;
    localparam logic [3:0] MEM_SB  = 4'd6;
    localparam logic [3:0] MEM_SH  = 4'd7;
    localparam logic [3:0] MEM_SW  = 4'd8;

    // UART window inside the MMU address map
    localparam logic [31:0] UART_DATA_ADDR = 32'hBFD0_03F8;
    localparam logic [31:0] UART_STAT_ADDR = 32'hBFD0_03FC;

    // Serial frame phases, shared by transmitter and receiver
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
               (op == MEM_LHU) || (op == MEM_LW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Byte FIFO between the UART receiver and the load path.
//               Head entry is presented combinationally.
//               A pop on an empty FIFO is ignored.
//               A push is accepted when the FIFO is not full, or when a pop
//               takes effect in the same cycle.
// Ports       : clk, rst (async, active low)
//               i_push/i_data  - write a received byte
//               i_pop          - remove the head entry
//               o_head         - current head byte
//               o_empty/o_full - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic [7:0] o_head,
    output logic       o_empty,
    output logic       o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_pop;
    logic          w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == C_FULL);
    assign o_head  = r_mem[r_rd_ptr];

    // A pop frees a slot in the same cycle, so a push while full still lands
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers are power-of-two wide and wrap naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_ctrl
// Description : 8N1 serial port behind the MMU UART window.
//               TX: 1-byte holding register feeding a shift-register FSM.
//               RX: synchronized, mid-bit sampling FSM feeding an RX FIFO.
// Ports       : clk, rst (async, active low)
//               uartOp_i         - MEM_* op, MEM_NOP when UART not addressed
//               uart_storeData_i - store data, [7:0] transmitted
//               stall_i          - access commits only when low
//               uart_load_data_o - {24'b0, FIFO head}, 0 when empty
//               dataReady        - RX FIFO not empty
//               writeReady       - TX holding register empty
//               txd / rxd        - serial line, idle high
// Revision    : 1.0 - initial release
// ============================================================================
module uart_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int RX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  uartOp_i,
    input  logic [31:0] uart_storeData_i,
    input  logic        stall_i,
    output logic [31:0] uart_load_data_o,
    output logic        dataReady,
    output logic        writeReady,
    output logic        txd,
    input  logic        rxd
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] C_BAUD_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] C_BAUD_HALF = CW'(DIV / 2 - 1);

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    logic w_wr_commit;
    logic w_rd_commit;
    logic w_unused_store;

    assign w_wr_commit    = is_store(uartOp_i) && !stall_i;
    assign w_rd_commit    = is_load(uartOp_i) && !stall_i;
    assign w_unused_store = ^uart_storeData_i[31:8];

    // ------------------------------------------------------------------
    // TX holding register
    // ------------------------------------------------------------------
    logic       r_hold_full;
    logic [7:0] r_hold_data;
    logic       r_tx_ovr;
    logic       w_tx_load;

    assign writeReady = !r_hold_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_full <= 1'b0;
            r_hold_data <= '0;
            r_tx_ovr    <= 1'b0;
        end else begin
            // w_tx_load only fires while full, so it never races an accept
            if (w_tx_load) begin
                r_hold_full <= 1'b0;
            end else if (w_wr_commit && !r_hold_full) begin
                r_hold_full <= 1'b1;
                r_hold_data <= uart_storeData_i[7:0];
            end
            r_tx_ovr <= r_tx_ovr | (w_wr_commit & r_hold_full);
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    uart_state_e   r_tx_state;
    uart_state_e   w_tx_state_next;
    logic [CW-1:0] r_tx_baud;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_shift;
    logic          r_txd;
    logic          w_tx_tick;
    logic          w_tx_line;

    assign w_tx_tick = (r_tx_baud == C_BAUD_LAST);
    assign txd       = r_txd;

    always_comb begin
        w_tx_state_next = r_tx_state;
        w_tx_load       = 1'b0;
        w_tx_line       = 1'b1;
        case (r_tx_state)
            ST_IDLE: begin
                if (r_hold_full) begin
                    w_tx_state_next = ST_START;
                    w_tx_load       = 1'b1;
                end
            end
            ST_START: begin
                w_tx_line = 1'b0;
                if (w_tx_tick) begin
                    w_tx_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                w_tx_line = r_tx_shift[0];
                if (w_tx_tick && (r_tx_bit == 3'd7)) begin
                    w_tx_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                // A waiting byte starts immediately, keeping frames back to back
                if (w_tx_tick) begin
                    if (r_hold_full) begin
                        w_tx_state_next = ST_START;
                        w_tx_load       = 1'b1;
                    end else begin
                        w_tx_state_next = ST_IDLE;
                    end
                end
            end
            default: w_tx_state_next = ST_IDLE;
        endcase
    end

    // txd is registered from the phase, so the line lags the state by one clock
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_state <= ST_IDLE;
            r_tx_baud  <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_next;
            r_txd      <= w_tx_line;
            if (w_tx_load) begin
                r_tx_shift <= r_hold_data;
                r_tx_baud  <= '0;
                r_tx_bit   <= '0;
            end else if (r_tx_state != ST_IDLE) begin
                r_tx_baud <= w_tx_tick ? '0 : r_tx_baud + 1'b1;
                if (w_tx_tick && (r_tx_state == ST_DATA)) begin
                    r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                    r_tx_bit   <= r_tx_bit + 3'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    uart_state_e   r_rx_state;
    uart_state_e   w_rx_state_next;
    logic          r_rx_meta;
    logic          r_rx_line;
    logic          r_rx_prev;
    logic [CW-1:0] r_rx_baud;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_shift;
    logic          r_rx_ferr;
    logic          r_rx_ovr;
    logic          w_rx_fall;
    logic          w_rx_tick;
    logic          w_rx_half;
    logic          w_rx_sample;
    logic          w_rx_push;
    logic          w_rx_cnt_clr;
    logic          w_rx_ferr_set;
    logic          w_rx_ferr_clr;
    logic          w_rx_drop;
    logic [7:0]    w_fifo_head;
    logic          w_fifo_empty;
    logic          w_fifo_full;

    assign w_rx_fall = r_rx_prev & ~r_rx_line;
    assign w_rx_tick = (r_rx_baud == C_BAUD_LAST);
    assign w_rx_half = (r_rx_baud == C_BAUD_HALF);

    always_comb begin
        w_rx_state_next = r_rx_state;
        w_rx_sample     = 1'b0;
        w_rx_push       = 1'b0;
        w_rx_cnt_clr    = 1'b0;
        w_rx_ferr_set   = 1'b0;
        w_rx_ferr_clr   = 1'b0;
        case (r_rx_state)
            ST_IDLE: begin
                if (w_rx_fall) begin
                    w_rx_state_next = ST_START;
                    w_rx_cnt_clr    = 1'b1;
                end
            end
            ST_START: begin
                // Mid start bit: a high line means the edge was a glitch.
                // Restarting the counter here puts later samples mid-bit.
                if (w_rx_half) begin
                    w_rx_cnt_clr = 1'b1;
                    if (r_rx_line) begin
                        w_rx_state_next = ST_IDLE;
                    end else begin
                        w_rx_state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_rx_tick) begin
                    w_rx_sample = 1'b1;
                    if (r_rx_bit == 3'd7) begin
                        w_rx_state_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                // After a framing error, hold here until the line idles high
                if (r_rx_ferr) begin
                    if (r_rx_line) begin
                        w_rx_state_next = ST_IDLE;
                        w_rx_ferr_clr   = 1'b1;
                    end
                end else if (w_rx_tick) begin
                    if (r_rx_line) begin
                        w_rx_push       = 1'b1;
                        w_rx_state_next = ST_IDLE;
                    end else begin
                        w_rx_ferr_set = 1'b1;
                    end
                end
            end
            default: w_rx_state_next = ST_IDLE;
        endcase
    end

    // A full FIFO only makes room for a push when a read commits alongside it
    assign w_rx_drop = w_rx_push & w_fifo_full & ~w_rd_commit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_meta  <= 1'b1;
            r_rx_line  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= ST_IDLE;
            r_rx_baud  <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_ferr  <= 1'b0;
            r_rx_ovr   <= 1'b0;
        end else begin
            r_rx_meta  <= rxd;
            r_rx_line  <= r_rx_meta;
            r_rx_prev  <= r_rx_line;
            r_rx_state <= w_rx_state_next;
            if (w_rx_cnt_clr || (r_rx_state == ST_IDLE) || w_rx_tick) begin
                r_rx_baud <= '0;
            end else begin
                r_rx_baud <= r_rx_baud + 1'b1;
            end
            if (r_rx_state == ST_START) begin
                r_rx_bit <= '0;
            end else if (w_rx_sample) begin
                r_rx_bit <= r_rx_bit + 3'd1;
            end
            if (w_rx_sample) begin
                r_rx_shift <= {r_rx_line, r_rx_shift[7:1]};
            end
            if (w_rx_ferr_set) begin
                r_rx_ferr <= 1'b1;
            end else if (w_rx_ferr_clr) begin
                r_rx_ferr <= 1'b0;
            end
            r_rx_ovr <= r_rx_ovr | w_rx_drop;
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO and load path
    // ------------------------------------------------------------------
    uart_rx_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rx_push),
        .i_data  (r_rx_shift),
        .i_pop   (w_rd_commit),
        .o_head  (w_fifo_head),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    assign dataReady        = !w_fifo_empty;
    assign uart_load_data_o = w_fifo_empty ? 32'b0 : {24'b0, w_fifo_head};

endmodule
`default_nettype wire

// File: tb/tb_uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_ctrl
// Description : Directed testbench for uart_ctrl with DIV = 16.
//               Table of per-cycle vectors for op decode and TX start timing,
//               plus hand-written sequences for frames, FIFO and line faults.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_ctrl;
    import uart_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  op;
    logic [31:0] sdata;
    logic        stall;
    logic [31:0] ldata;
    logic        dr;
    logic        wr;
    logic        txd;
    logic        rxd;

    int n_vec;
    int n_bad;

    uart_ctrl #(
        .CLK_FREQ (16),
        .BAUD     (1),
        .RX_DEPTH (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .uartOp_i         (op),
        .uart_storeData_i (sdata),
        .stall_i          (stall),
        .uart_load_data_o (ldata),
        .dataReady        (dr),
        .writeReady       (wr),
        .txd              (txd),
        .rxd              (rxd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Waits for a start bit and samples each bit in its middle
    task automatic tx_capture(output logic [7:0] b);
        int t;
        t = 0;
        b = '0;
        @(negedge clk);
        while (txd !== 1'b0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("tx_start_seen", (t < 400), 1);
        repeat (7) @(negedge clk);
        chk("tx_start_mid", txd, 0);
        for (int i = 0; i < 8; i++) begin
            repeat (16) @(negedge clk);
            b[i] = txd;
        end
        repeat (16) @(negedge clk);
        chk("tx_stop_mid", txd, 1);
    endtask

    // Drives one frame on rxd; reports dataReady just as the stop bit begins
    task automatic rx_send(input logic [7:0] b, input logic stop_bit, output logic dr_at_stop);
        rxd = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (16) @(negedge clk);
        end
        dr_at_stop = dr;
        rxd = stop_bit;
        repeat (16) @(negedge clk);
        rxd = 1'b1;
    endtask

    typedef struct {
        logic [3:0] op;
        logic       stall;
        logic [7:0] data;
        logic       exp_wr;
        logic       exp_txd;
        logic       exp_dr;
    } vec_t;

    vec_t       vt [8];
    logic [9:0] frame_a5;
    logic [7:0] b0;
    logic [7:0] b1;
    logic       drs;
    logic       seen_low;
    int         t;

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b0;
        op    = MEM_NOP;
        sdata = '0;
        stall = 1'b0;
        rxd   = 1'b1;

        // ---------------- reset release ----------------
        repeat (3) @(negedge clk);
        chk("rst_txd", txd, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wr", wr, 1);
        chk("rst_dr", dr, 0);
        chk("rst_ldata", ldata, 0);
        chk("rst_txd_rel", txd, 1);

        // ---------------- vector table: decode and first frame start -------
        vt[0] = '{MEM_NOP, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        vt[1] = '{MEM_SW,  1'b1, 8'h11, 1'b1, 1'b1, 1'b0};
        vt[2] = '{MEM_SH,  1'b1, 8'h22, 1'b1, 1'b1, 1'b0};
        vt[3] = '{MEM_LW,  1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        vt[4] = '{MEM_LBU, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        vt[5] = '{MEM_SB,  1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
        vt[6] = '{MEM_NOP, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        vt[7] = '{MEM_NOP, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            op    = vt[i].op;
            stall = vt[i].stall;
            sdata = {24'hFFFFFF, vt[i].data};
            @(negedge clk);
            chk($sformatf("vec%0d_wr", i), wr, vt[i].exp_wr);
            chk($sformatf("vec%0d_txd", i), txd, vt[i].exp_txd);
            chk($sformatf("vec%0d_dr", i), dr, vt[i].exp_dr);
            chk($sformatf("vec%0d_ldata", i), ldata, 0);
        end
        op    = MEM_NOP;
        stall = 1'b0;

        // Rest of the 0xA5 frame, clock by clock (first start sample done)
        frame_a5 = {1'b1, 8'hA5, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < 16; k++) begin
                if (!(b == 0 && k == 0)) begin
                    @(negedge clk);
                    chk($sformatf("tx_a5_bit%0d", b), txd, frame_a5[b]);
                end
            end
        end
        @(negedge clk);
        chk("tx_a5_idle", txd, 1);
        chk("tx_ovr_clear", dut.r_tx_ovr, 0);

        // ---------------- two stores, then one too many ----------------
        fork
            begin
                tx_capture(b0);
                chk("tx_first_byte", b0, 8'h41);
                tx_capture(b1);
                chk("tx_second_byte", b1, 8'h42);
            end
            begin
                op    = MEM_SB;
                sdata = 32'h0000_0041;
                @(negedge clk);
                op = MEM_NOP;
                t  = 0;
                while (!wr && t < 64) begin
                    @(negedge clk);
                    t++;
                end
                chk("tx_wr_back", wr, 1);
                op    = MEM_SB;
                sdata = 32'h0000_0042;
                @(negedge clk);
                chk("tx_hold_busy", wr, 0);
                op    = MEM_SB;
                sdata = 32'h0000_0043;
                @(negedge clk);
                op = MEM_NOP;
                chk("tx_ovr_set", dut.r_tx_ovr, 1);
            end
        join
        seen_low = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (txd == 1'b0) seen_low = 1'b1;
        end
        chk("tx_no_third_frame", seen_low, 0);

        // ---------------- asynchronous reset mid-frame ----------------
        op    = MEM_SB;
        sdata = 32'h0000_0000;
        @(negedge clk);
        op = MEM_NOP;
        t  = 0;
        while (txd !== 1'b0 && t < 64) begin
            @(negedge clk);
            t++;
        end
        chk("rst_mid_start_seen", txd, 0);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_txd", txd, 1);
        chk("rst_async_wr", wr, 1);
        chk("rst_async_ovr", dut.r_tx_ovr, 0);
        @(negedge clk);
        rst = 1'b1;
        seen_low = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (txd == 1'b0) seen_low = 1'b1;
        end
        chk("rst_frame_abandoned", seen_low, 0);

        // ---------------- receive 0x5A, stalled read ----------------
        chk("rx_empty_before", dr, 0);
        rx_send(8'h5A, 1'b1, drs);
        chk("rx_dr_before_stop", drs, 0);
        chk("rx_dr_after_stop", dr, 1);
        op    = MEM_LW;
        stall = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) stall = 1'b0;
            #1;
            chk($sformatf("rx_stall_ldata%0d", c), ldata, 32'h0000_005A);
            @(negedge clk);
        end
        op = MEM_NOP;
        #1;
        chk("rx_pop_dr", dr, 0);
        chk("rx_pop_ldata", ldata, 0);

        // ---------------- overflow with five frames ----------------
        chk("rx_ovr_clear", dut.r_rx_ovr, 0);
        for (int i = 1; i <= 5; i++) begin
            rx_send(8'(i), 1'b1, drs);
        end
        repeat (4) @(negedge clk);
        chk("rx_full_dr", dr, 1);
        chk("rx_ovr_set", dut.r_rx_ovr, 1);
        for (int i = 0; i < 5; i++) begin
            op = MEM_LW;
            #1;
            chk($sformatf("rx_fifo_read%0d", i), ldata, (i < 4) ? 32'(i + 1) : 32'h0);
            @(negedge clk);
        end
        op = MEM_NOP;
        chk("rx_drained", dr, 0);

        // ---------------- glitch, framing error, then good frame ----------
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        chk("rx_glitch_no_push", dr, 0);
        rx_send(8'h77, 1'b0, drs);
        repeat (40) @(negedge clk);
        chk("rx_ferr_no_push", dr, 0);
        rx_send(8'h33, 1'b1, drs);
        repeat (4) @(negedge clk);
        chk("rx_good_dr", dr, 1);
        op = MEM_LB;
        #1;
        chk("rx_good_ldata", ldata, 32'h0000_0033);
        @(negedge clk);
        op = MEM_NOP;
        chk("rx_good_popped", dr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
